// File: rtl/io_port_bank.sv
// io_port_bank: bidirectional pad-bank controller for the risc8 GPIO port.
// Per-bit turnaround FSM inserts TURN tristate cycles before any bit drives,
// and pad inputs pass through a SYNC-stage synchroniser before the core sees them.
// Optional feature macro: IO_PORT_EDGE_IRQ_EN (per-bit rising-edge interrupt status).
module io_port_bank #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned TURN  = 2,
  parameter int unsigned SYNC  = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_en,
  input  logic [1:0]       wr_sel,
  input  logic [WIDTH-1:0] wr_data,
  input  logic [1:0]       rd_sel,
  output logic [WIDTH-1:0] rd_data,
  input  logic [WIDTH-1:0] pad_c,
  output logic [WIDTH-1:0] pad_i,
  output logic [WIDTH-1:0] pad_oen,
  output logic [WIDTH-1:0] pad_ie,
  output logic             irq,
  input  logic [WIDTH-1:0] irq_ack
);

  localparam int unsigned CNT_W = 4;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(TURN - 1);

  typedef enum logic [1:0] {
    ST_IN     = 2'd0,
    ST_TO_OUT = 2'd1,
    ST_OUT    = 2'd2,
    ST_TO_IN  = 2'd3
  } state_t;

  logic [WIDTH-1:0] out_reg;
  logic [WIDTH-1:0] dir_reg;
  state_t           state_q [WIDTH];
  state_t           state_d [WIDTH];
  logic [CNT_W-1:0] cnt_q   [WIDTH];
  logic [CNT_W-1:0] cnt_d   [WIDTH];
  logic [WIDTH-1:0] oen_d;
  logic [WIDTH-1:0] ie_d;
  logic [WIDTH-1:0] in_mask;
  logic [WIDTH-1:0] busy_mask;
  logic [WIDTH-1:0] sync_q  [SYNC];
  logic [WIDTH-1:0] sync_last;

  // Core-visible registers: plain, set and clear writes
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_reg <= '0;
      dir_reg <= '0;
    end else if (wr_en) begin
      case (wr_sel)
        2'd0:    out_reg <= wr_data;
        2'd1:    dir_reg <= wr_data;
        2'd2:    out_reg <= out_reg | wr_data;
        default: out_reg <= out_reg & ~wr_data;
      endcase
    end
  end

  assign pad_i = out_reg;

  // Turnaround FSM state/counter and registered pad controls
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < WIDTH; i++) begin
        state_q[i] <= ST_IN;
        cnt_q[i]   <= '0;
      end
      pad_oen <= '1;
      pad_ie  <= '1;
    end else begin
      for (int i = 0; i < WIDTH; i++) begin
        state_q[i] <= state_d[i];
        cnt_q[i]   <= cnt_d[i];
      end
      pad_oen <= oen_d;
      pad_ie  <= ie_d;
    end
  end

  // Next-state: acts on the registered direction, never on wr_data
  always_comb begin
    for (int i = 0; i < WIDTH; i++) begin
      state_d[i] = state_q[i];
      cnt_d[i]   = cnt_q[i];
      case (state_q[i])
        ST_IN: begin
          if (dir_reg[i]) begin
            state_d[i] = ST_TO_OUT;
            cnt_d[i]   = CNT_LOAD;
          end
        end
        ST_TO_OUT: begin
          if (!dir_reg[i]) begin
            state_d[i] = ST_IN;
          end else if (cnt_q[i] == '0) begin
            state_d[i] = ST_OUT;
          end else begin
            cnt_d[i] = cnt_q[i] - CNT_W'(1);
          end
        end
        ST_OUT: begin
          if (!dir_reg[i]) begin
            state_d[i] = ST_TO_IN;
            cnt_d[i]   = CNT_LOAD;
          end
        end
        default: begin
          if (dir_reg[i]) begin
            state_d[i] = ST_TO_OUT;
            cnt_d[i]   = CNT_LOAD;
          end else if (cnt_q[i] == '0) begin
            state_d[i] = ST_IN;
          end else begin
            cnt_d[i] = cnt_q[i] - CNT_W'(1);
          end
        end
      endcase
    end
  end

  // Output decode: pad controls follow the next state so they register in step with it
  always_comb begin
    oen_d     = '1;
    ie_d      = '0;
    in_mask   = '0;
    busy_mask = '0;
    for (int i = 0; i < WIDTH; i++) begin
      oen_d[i]     = (state_d[i] != ST_OUT);
      ie_d[i]      = (state_d[i] == ST_IN);
      in_mask[i]   = (state_q[i] == ST_IN);
      busy_mask[i] = (state_q[i] == ST_TO_OUT) || (state_q[i] == ST_TO_IN);
    end
  end

  // Input synchroniser on gated pad receiver data
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int s = 0; s < SYNC; s++) begin
        sync_q[s] <= '0;
      end
    end else begin
      sync_q[0] <= pad_c & pad_ie;
      for (int s = 1; s < SYNC; s++) begin
        sync_q[s] <= sync_q[s-1];
      end
    end
  end

  assign sync_last = sync_q[SYNC-1];

  // Zero-latency read mux; pin view shows out_reg for bits not in IN
  always_comb begin
    rd_data = '0;
    case (rd_sel)
      2'd0:    rd_data = (sync_last & in_mask) | (out_reg & ~in_mask);
      2'd1:    rd_data = out_reg;
      2'd2:    rd_data = dir_reg;
      default: rd_data = busy_mask;
    endcase
  end

`ifdef IO_PORT_EDGE_IRQ_EN
  logic [WIDTH-1:0] hist_q;
  logic [WIDTH-1:0] status_q;
  logic [WIDTH-1:0] status_d;

  // Status update: a new rising edge outranks a coincident acknowledge
  always_comb begin
    status_d = (status_q & ~irq_ack) | (in_mask & sync_last & ~hist_q);
  end

  // Edge history, status bits and registered interrupt line
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hist_q   <= '0;
      status_q <= '0;
      irq      <= 1'b0;
    end else begin
      hist_q   <= sync_last;
      status_q <= status_d;
      irq      <= |status_d;
    end
  end
`else
  logic unused_irq_ack;
  assign unused_irq_ack = ^irq_ack;
  assign irq            = 1'b0;
`endif

endmodule
